// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: state encoding and defaults.
package serial_sub_pkg;

   localparam int DEFAULT_WIDTH = 4;
   localparam int STATE_W       = 2;

   typedef enum logic [STATE_W-1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage : serial_sub_pkg

// File: rtl/serial_subtractor_full_subtractor_bit.sv
// One-bit full subtractor: d = a - b - borrow_in, with borrow-out.
module full_subtractor_bit
(
   input  logic a_i,
   input  logic b_i,
   input  logic br_in,
   output logic d,
   output logic br_out
);

   // Difference bit and borrow-out of a single bit position
   always_comb begin
      d      = a_i ^ b_i ^ br_in;
      br_out = (~a_i & b_i) | (~(a_i ^ b_i) & br_in);
   end

endmodule : full_subtractor_bit

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b over WIDTH cycles, LSB first.
// Start/busy/done handshake; the result is published when the last bit is
// processed and held until the next accepted start.
// Optional signed-overflow flag: define SERIAL_SUB_SIGNED_OVF_EN.
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             ovf
);

   localparam int             CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   state_t             state_q;
   state_t             state_d;
   logic               accept;
   logic               last_bit;
   logic [WIDTH-1:0]   a_sh;
   logic [WIDTH-1:0]   b_sh;
   logic               br_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [WIDTH-2:0]   work_q;
   logic               d_bit;
   logic               br_next;
   logic [WIDTH-1:0]   result;

   // A start is honoured only when no operation is in flight
   assign accept   = start & ((state_q == IDLE) | (state_q == DONE));
   assign last_bit = (state_q == SHIFT) & (cnt_q == LAST_CNT);

   // The newest difference bit enters from the MSB side of the partial result
   assign result = {d_bit, work_q};

   full_subtractor_bit u_bit (
      .a_i    (a_sh[0]),
      .b_i    (b_sh[0]),
      .br_in  (br_q),
      .d      (d_bit),
      .br_out (br_next)
   );

   // Next-state decode and handshake outputs
   always_comb begin
      state_d = state_q;
      busy    = 1'b0;
      done    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) state_d = SHIFT;
         end
         SHIFT: begin
            busy = 1'b1;
            if (cnt_q == LAST_CNT) state_d = DONE;
         end
         DONE: begin
            done    = 1'b1;
            state_d = start ? SHIFT : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Bit counter: restarts on accept, advances once per processed bit
   always_ff @(posedge clk) begin
      if (reset)                  cnt_q <= '0;
      else if (accept)            cnt_q <= '0;
      else if (state_q == SHIFT)  cnt_q <= cnt_q + CNT_W'(1);
   end

   // Operand shift registers: loaded on accept, shifted right while busy
   always_ff @(posedge clk) begin
      if (reset) begin
         a_sh <= '0;
         b_sh <= '0;
      end else if (accept) begin
         a_sh <= a;
         b_sh <= b;
      end else if (state_q == SHIFT) begin
         a_sh <= a_sh >> 1;
         b_sh <= b_sh >> 1;
      end
   end

   // Rippled borrow flip-flop, cleared at the start of every operation
   always_ff @(posedge clk) begin
      if (reset)                  br_q <= 1'b0;
      else if (accept)            br_q <= 1'b0;
      else if (state_q == SHIFT)  br_q <= br_next;
   end

   // Working result register, kept apart from diff so the old result stays visible
   always_ff @(posedge clk) begin
      if (reset)                  work_q <= '0;
      else if (accept)            work_q <= '0;
      else if (state_q == SHIFT)  work_q <= result[WIDTH-1:1];
   end

   // Publish diff and borrow on the edge that processes the final bit
   always_ff @(posedge clk) begin
      if (reset) begin
         diff   <= '0;
         borrow <= 1'b0;
      end else if (last_bit) begin
         diff   <= result;
         borrow <= br_next;
      end
   end

`ifdef SERIAL_SUB_SIGNED_OVF_EN
   logic a_msb_q;
   logic b_msb_q;

   // Operand sign bits, kept because the shift registers lose them
   always_ff @(posedge clk) begin
      if (reset) begin
         a_msb_q <= 1'b0;
         b_msb_q <= 1'b0;
      end else if (accept) begin
         a_msb_q <= a[WIDTH-1];
         b_msb_q <= b[WIDTH-1];
      end
   end

   // Signed overflow: operand signs differ and the result sign differs from a
   always_ff @(posedge clk) begin
      if (reset)         ovf <= 1'b0;
      else if (last_bit) ovf <= (a_msb_q ^ b_msb_q) & (d_bit ^ a_msb_q);
   end
`else
   assign ovf = 1'b0;
`endif

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=4) against an arithmetic model.
module tb_serial_subtractor;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         borrow;
   logic         ovf;

   int n_compared   = 0;
   int n_mismatched = 0;

   logic [W-1:0] prev_diff;
   logic         prev_borrow;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .diff   (diff),
      .borrow (borrow),
      .ovf    (ovf)
   );

   always #5 clk = ~clk;

   // Reference: plain unsigned modular subtraction
   function automatic logic [W-1:0] model_diff(input int av, input int bv);
      int r;
      r = (av - bv + 16) % 16;
      return r[W-1:0];
   endfunction

   function automatic logic model_borrow(input int av, input int bv);
      return av < bv;
   endfunction

   // Reference: signed two's-complement overflow from integer range
   function automatic logic model_ovf(input int av, input int bv);
`ifdef SERIAL_SUB_SIGNED_OVF_EN
      int sa, sb, sd;
      sa = (av >= 8) ? av - 16 : av;
      sb = (bv >= 8) ? bv - 16 : bv;
      sd = sa - sb;
      return (sd > 7) || (sd < -8);
`else
      return 1'b0;
`endif
   endfunction

   // Drive operands with a one-cycle start pulse through the accepting edge
   task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv);
      @(negedge clk);
      a     = av;
      b     = bv;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Wait (bounded) for done, counting busy cycles and noting diff mid-operation
   task automatic run_to_done(output int busy_cnt, output bit got_done,
                              output logic [W-1:0] mid_diff, output logic mid_borrow);
      busy_cnt   = 0;
      got_done   = 1'b0;
      mid_diff   = 'x;
      mid_borrow = 1'bx;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done) begin
            got_done = 1'b1;
            break;
         end
         if (busy) begin
            if (busy_cnt == 0) begin
               mid_diff   = diff;
               mid_borrow = borrow;
            end
            busy_cnt++;
         end
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      repeat (2) @(negedge clk);
      n_compared++;
      if ({busy, done, diff, borrow, ovf} !== 8'b0) begin
         n_mismatched++;
         $display("[TB] FAIL reset_outputs got busy=%b done=%b diff=%h borrow=%b ovf=%b want all 0",
                  busy, done, diff, borrow, ovf);
      end
      reset = 1'b0;
      @(negedge clk);
      n_compared++;
      if ({busy, done} !== 2'b00) begin
         n_mismatched++;
         $display("[TB] FAIL idle_after_reset got busy=%b done=%b want 0 0", busy, done);
      end
      prev_diff   = '0;
      prev_borrow = 1'b0;
   endtask

   task automatic check_op(input string tag, input int av, input int bv, input bit check_mid);
      int           bc;
      bit           gd;
      logic [W-1:0] md;
      logic         mb;
      applyStimulus(W'(av), W'(bv));
      run_to_done(bc, gd, md, mb);
      n_compared++;
      if (gd !== 1'b1) begin
         n_mismatched++;
         $display("[TB] FAIL %s_done_timeout got none want done within 20 cycles", tag);
      end
      n_compared++;
      if (bc !== W) begin
         n_mismatched++;
         $display("[TB] FAIL %s_busy_cycles got %0d want %0d", tag, bc, W);
      end
      if (check_mid) begin
         n_compared++;
         if ({md, mb} !== {prev_diff, prev_borrow}) begin
            n_mismatched++;
            $display("[TB] FAIL %s_held_during_shift got diff=%h borrow=%b want diff=%h borrow=%b",
                     tag, md, mb, prev_diff, prev_borrow);
         end
      end
      n_compared++;
      if ({diff, borrow} !== {model_diff(av, bv), model_borrow(av, bv)}) begin
         n_mismatched++;
         $display("[TB] FAIL %s_result a=%0d b=%0d got diff=%h borrow=%b want diff=%h borrow=%b",
                  tag, av, bv, diff, borrow, model_diff(av, bv), model_borrow(av, bv));
      end
      n_compared++;
      if (ovf !== model_ovf(av, bv)) begin
         n_mismatched++;
         $display("[TB] FAIL %s_ovf a=%0d b=%0d got %b want %b", tag, av, bv, ovf, model_ovf(av, bv));
      end
      prev_diff   = model_diff(av, bv);
      prev_borrow = model_borrow(av, bv);
   endtask

   task automatic test_directed;
      int pa [4] = '{9, 3, 0, 15};
      int pb [4] = '{3, 9, 15, 15};
      for (int k = 0; k < 4; k++) begin
         check_op("directed", pa[k], pb[k], 1'b1);
         @(negedge clk);
         n_compared++;
         if ({done, busy} !== 2'b00 || diff !== prev_diff) begin
            n_mismatched++;
            $display("[TB] FAIL done_single_pulse got done=%b busy=%b diff=%h want 0 0 %h",
                     done, busy, diff, prev_diff);
         end
      end
   endtask

   task automatic test_random;
      for (int k = 0; k < 24; k++) begin
         check_op("random", int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1'b1);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
   endtask

   task automatic test_back_to_back;
      int  pa [4] = '{5, 12, 1, 8};
      int  pb [4] = '{2, 7, 14, 8};
      int  bc;
      bit  gd;
      @(negedge clk);
      a     = W'(pa[0]);
      b     = W'(pb[0]);
      start = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk);
         bc = 0;
         gd = 1'b0;
         for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) begin
               gd = 1'b1;
               break;
            end
            if (busy) bc++;
            a = W'($urandom_range(0, 15));
            b = W'($urandom_range(0, 15));
         end
         n_compared++;
         if (gd !== 1'b1 || bc !== W) begin
            n_mismatched++;
            $display("[TB] FAIL b2b_timing op=%0d got done=%b busy_cycles=%0d want 1 %0d", k, gd, bc, W);
         end
         n_compared++;
         if ({diff, borrow} !== {model_diff(pa[k], pb[k]), model_borrow(pa[k], pb[k])}) begin
            n_mismatched++;
            $display("[TB] FAIL b2b_result op=%0d got diff=%h borrow=%b want diff=%h borrow=%b",
                     k, diff, borrow, model_diff(pa[k], pb[k]), model_borrow(pa[k], pb[k]));
         end
         if (k < 3) begin
            a = W'(pa[k+1]);
            b = W'(pb[k+1]);
         end else begin
            start = 1'b0;
         end
      end
      @(negedge clk);
      n_compared++;
      if ({done, busy} !== 2'b00) begin
         n_mismatched++;
         $display("[TB] FAIL b2b_end got done=%b busy=%b want 0 0", done, busy);
      end
      prev_diff   = model_diff(pa[3], pb[3]);
      prev_borrow = model_borrow(pa[3], pb[3]);
   endtask

   task automatic test_reset_mid_shift;
      int done_cnt;
      check_op("pre_reset", 9, 3, 1'b0);
      applyStimulus(4'd3, 4'd9);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      n_compared++;
      if ({busy, done, diff, borrow, ovf} !== 8'b0) begin
         n_mismatched++;
         $display("[TB] FAIL mid_shift_reset got busy=%b done=%b diff=%h borrow=%b ovf=%b want all 0",
                  busy, done, diff, borrow, ovf);
      end
      reset    = 1'b0;
      done_cnt = 0;
      repeat (8) begin
         @(negedge clk);
         if (done || busy) done_cnt++;
      end
      n_compared++;
      if (done_cnt !== 0) begin
         n_mismatched++;
         $display("[TB] FAIL discarded_op_activity got %0d busy/done cycles want 0", done_cnt);
      end
      prev_diff   = '0;
      prev_borrow = 1'b0;
   endtask

   task automatic test_ovf;
      check_op("ovf_7_minus_neg8", 7, 8, 1'b1);
      check_op("ovf_5_minus_3", 5, 3, 1'b1);
      check_op("ovf_neg8_minus_1", 8, 1, 1'b1);
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_reset_mid_shift();
      test_ovf();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule : tb_serial_subtractor
